// File: rtl/siphash_ctrl_if.sv
// Bus between the SipHash sequencer, its upstream/downstream and the external round stage.
interface siphash_ctrl_if;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         msg_valid;
  logic         msg_ready;
  logic [63:0]  msg_data;
  logic         msg_last;
  logic         hash_valid;
  logic         hash_ready;
  logic [63:0]  hash;
  logic [63:0]  rnd_iv0, rnd_iv1, rnd_iv2, rnd_iv3;
  logic [63:0]  rnd_ov0, rnd_ov1, rnd_ov2, rnd_ov3;

  // Sequencer side
  modport slave (
    input  start, key, msg_valid, msg_data, msg_last, hash_ready,
           rnd_ov0, rnd_ov1, rnd_ov2, rnd_ov3,
    output busy, msg_ready, hash_valid, hash,
           rnd_iv0, rnd_iv1, rnd_iv2, rnd_iv3
  );

  // Environment side: message source, tag sink and round stage
  modport master (
    output start, key, msg_valid, msg_data, msg_last, hash_ready,
           rnd_ov0, rnd_ov1, rnd_ov2, rnd_ov3,
    input  busy, msg_ready, hash_valid, hash,
           rnd_iv0, rnd_iv1, rnd_iv2, rnd_iv3
  );
endinterface

// File: rtl/siphash_ctrl.sv
// SipHash-c-d sequencer driving one external registered round stage.
// Round inputs are issued combinationally; the stage result returns one
// cycle later and is fed straight back, so chained rounds cost a cycle each.
module siphash_ctrl #(
  parameter int C_ROUNDS = 2,
  parameter int D_ROUNDS = 4
) (
  input  logic           clk,
  input  logic           rst,
  siphash_ctrl_if.slave  bus
);

  localparam int MAX_R = (C_ROUNDS > D_ROUNDS) ? C_ROUNDS : D_ROUNDS;
  localparam int CNT_W = $clog2(MAX_R + 1);
  localparam logic [CNT_W-1:0] C_LIM = CNT_W'(C_ROUNDS);
  localparam logic [CNT_W-1:0] D_LIM = CNT_W'(D_ROUNDS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_CROUND, S_DROUND, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      v0_q, v1_q, v2_q, v3_q;
  logic [63:0]      v0_d, v1_d, v2_d, v3_d;
  logic [63:0]      m_q, m_d;
  logic             last_q, last_d;
  logic [63:0]      hash_q, hash_d;

  wire [63:0] k0 = bus.key[63:0];
  wire [63:0] k1 = bus.key[127:64];

  // State and datapath registers; reset aborts any hash in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      v0_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      v3_q    <= '0;
      m_q     <= '0;
      last_q  <= 1'b0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      m_q     <= m_d;
      last_q  <= last_d;
      hash_q  <= hash_d;
    end
  end

  // Next-state, round-stage feed and state updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    v3_d        = v3_q;
    m_d         = m_q;
    last_d      = last_q;
    hash_d      = hash_q;
    bus.rnd_iv0 = '0;
    bus.rnd_iv1 = '0;
    bus.rnd_iv2 = '0;
    bus.rnd_iv3 = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          v0_d    = k0 ^ 64'h736f6d6570736575;
          v1_d    = k1 ^ 64'h646f72616e646f6d;
          v2_d    = k0 ^ 64'h6c7967656e657261;
          v3_d    = k1 ^ 64'h7465646279746573;
          state_d = S_ABSORB;
        end
      end
      S_ABSORB: begin
        // First compression round is issued on the accepting edge
        bus.rnd_iv0 = v0_q;
        bus.rnd_iv1 = v1_q;
        bus.rnd_iv2 = v2_q;
        bus.rnd_iv3 = v3_q ^ bus.msg_data;
        if (bus.msg_valid) begin
          m_d     = bus.msg_data;
          last_d  = bus.msg_last;
          cnt_d   = ONE;
          state_d = S_CROUND;
        end
      end
      S_CROUND: begin
        if (cnt_q < C_LIM) begin
          bus.rnd_iv0 = bus.rnd_ov0;
          bus.rnd_iv1 = bus.rnd_ov1;
          bus.rnd_iv2 = bus.rnd_ov2;
          bus.rnd_iv3 = bus.rnd_ov3;
          cnt_d       = cnt_q + ONE;
        end else if (!last_q) begin
          v0_d    = bus.rnd_ov0 ^ m_q;
          v1_d    = bus.rnd_ov1;
          v2_d    = bus.rnd_ov2;
          v3_d    = bus.rnd_ov3;
          state_d = S_ABSORB;
        end else begin
          // Fold the last word and the finalisation constant, issue round 1 of d
          bus.rnd_iv0 = bus.rnd_ov0 ^ m_q;
          bus.rnd_iv1 = bus.rnd_ov1;
          bus.rnd_iv2 = bus.rnd_ov2 ^ 64'hff;
          bus.rnd_iv3 = bus.rnd_ov3;
          cnt_d       = ONE;
          state_d     = S_DROUND;
        end
      end
      S_DROUND: begin
        if (cnt_q < D_LIM) begin
          bus.rnd_iv0 = bus.rnd_ov0;
          bus.rnd_iv1 = bus.rnd_ov1;
          bus.rnd_iv2 = bus.rnd_ov2;
          bus.rnd_iv3 = bus.rnd_ov3;
          cnt_d       = cnt_q + ONE;
        end else begin
          hash_d  = bus.rnd_ov0 ^ bus.rnd_ov1 ^ bus.rnd_ov2 ^ bus.rnd_ov3;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.hash_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.msg_ready  = (state_q == S_ABSORB);
  assign bus.hash_valid = (state_q == S_DONE);
  assign bus.hash       = hash_q;

endmodule
